// File: rtl/cache_pkg.sv
// Shared cache definitions: controller state encoding, geometry derivation
// helpers and the line-address builder used by the controller and memory models.
package cache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_ALLOCATE  = 2'd2,
      ST_RESOLVE   = 2'd3
   } state_t;

   function automatic int offset_w(input int line_bytes);
      return $clog2(line_bytes);
   endfunction

   function automatic int index_w(input int num_lines);
      return $clog2(num_lines);
   endfunction

   function automatic int tag_w(input int addr_w, input int num_lines, input int line_bytes);
      return addr_w - $clog2(num_lines) - $clog2(line_bytes);
   endfunction

   function automatic int line_w(input int line_bytes);
      return 8 * line_bytes;
   endfunction

   // {tag, index, offset=0}; callers size-cast the result to their address width.
   function automatic logic [63:0] line_addr(input logic [63:0] tag, input logic [63:0] index,
                                             input int idx_bits, input int off_bits);
      return (tag << (idx_bits + off_bits)) | (index << off_bits);
   endfunction

endpackage

// File: rtl/dcache_stall_ctrl_if.sv
// Line-granular memory bus between the data-cache controller and backing memory.
//
// Handshake: the master raises mem_req and holds mem_we/mem_addr/mem_wdata
// stable until the slave returns a single-cycle mem_ack; mem_rdata is valid
// only in that ack cycle. A request still high in the cycle after an ack is a
// new transaction.
interface dcache_stall_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [LINE_W-1:0] mem_wdata;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                   input  mem_rdata, mem_ack);
   modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                   output mem_rdata, mem_ack);
endinterface

// File: rtl/dcache_line_store.sv
// Tag/valid/dirty/data storage for a direct-mapped cache. Reads are
// asynchronous; one synchronous write port either installs a whole clean line
// or merges one word and marks the line dirty.
module dcache_line_store
   import cache_pkg::*;
#(
   parameter int NUM_LINES  = 16,
   parameter int LINE_BYTES = 32,
   parameter int ADDR_W     = 32,
   localparam int INDEX_W   = index_w(NUM_LINES),
   localparam int TAG_W     = tag_w(ADDR_W, NUM_LINES, LINE_BYTES),
   localparam int LINE_W    = line_w(LINE_BYTES),
   localparam int WSEL_W    = offset_w(LINE_BYTES) - 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [INDEX_W-1:0] rd_idx_i,
   output logic               rd_valid_o,
   output logic               rd_dirty_o,
   output logic [TAG_W-1:0]   rd_tag_o,
   output logic [LINE_W-1:0]  rd_line_o,
   input  logic               wr_en_i,
   input  logic               wr_line_i,
   input  logic [INDEX_W-1:0] wr_idx_i,
   input  logic [TAG_W-1:0]   wr_tag_i,
   input  logic [LINE_W-1:0]  wr_line_data_i,
   input  logic [WSEL_W-1:0]  wr_word_sel_i,
   input  logic [31:0]        wr_word_i
);

   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [LINE_W-1:0]    data_q [NUM_LINES];

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_dirty_o = dirty_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_line_o  = data_q[rd_idx_i];

   // Status bits: cleared by reset; a line install is clean, a word merge dirties.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (wr_en_i) begin
         valid_q[wr_idx_i] <= 1'b1;
         dirty_q[wr_idx_i] <= !wr_line_i;
      end
   end

   // Tag and data arrays carry no reset; valid_q qualifies their contents.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         if (wr_line_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_line_data_i;
         end else begin
            data_q[wr_idx_i][{wr_word_sel_i, 5'b0} +: 32] <= wr_word_i;
         end
      end
   end

endmodule

// File: rtl/dcache_stall_ctrl.sv
// Direct-mapped write-back/write-allocate L1 D-cache controller. Hits complete
// in the access cycle; a miss freezes the pipeline via cpu_stall_o while the
// dirty victim is written back and the line refilled, then the latched access
// completes in a single RESOLVE cycle with the stall released.
module dcache_stall_ctrl
   import cache_pkg::*;
#(
   parameter int NUM_LINES  = 16,
   parameter int LINE_BYTES = 32,
   parameter int ADDR_W     = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                cpu_req_i,
   input  logic                cpu_we_i,
   input  logic [ADDR_W-1:0]   cpu_addr_i,
   input  logic [31:0]         cpu_wdata_i,
   output logic [31:0]         cpu_rdata_o,
   output logic                cpu_stall_o,
   dcache_stall_ctrl_if.master mem_if,
   output state_t              dbg_state_o
);

   localparam int OFFSET_W = offset_w(LINE_BYTES);
   localparam int INDEX_W  = index_w(NUM_LINES);
   localparam int TAG_W    = tag_w(ADDR_W, NUM_LINES, LINE_BYTES);
   localparam int LINE_W   = line_w(LINE_BYTES);
   localparam int WSEL_W   = OFFSET_W - 2;

   state_t            state_q, state_d;
   logic [ADDR_W-1:2] lat_addr_q;
   logic              lat_we_q;
   logic [31:0]       lat_wdata_q;
   logic              latch_en;

   logic [ADDR_W-1:2]  act_addr;
   logic [INDEX_W-1:0] act_idx;
   logic [TAG_W-1:0]   act_tag;
   logic [WSEL_W-1:0]  act_word;
   logic [31:0]        act_wdata;
   logic               rd_valid, rd_dirty, hit;
   logic [TAG_W-1:0]   rd_tag;
   logic [LINE_W-1:0]  rd_line;
   logic [31:0]        sel_word;
   logic               wr_en, wr_line;
   logic               unused_addr_bits;

   // Byte lane bits are meaningless for word-only accesses.
   assign unused_addr_bits = ^cpu_addr_i[1:0];

   // The live CPU address is only trusted in IDLE; afterwards the latched copy drives everything.
   assign act_addr  = (state_q == ST_IDLE) ? cpu_addr_i[ADDR_W-1:2] : lat_addr_q;
   assign act_wdata = (state_q == ST_IDLE) ? cpu_wdata_i : lat_wdata_q;
   assign act_idx   = act_addr[OFFSET_W +: INDEX_W];
   assign act_tag   = act_addr[ADDR_W-1 -: TAG_W];
   assign act_word  = act_addr[OFFSET_W-1:2];
   assign hit       = rd_valid && (rd_tag == act_tag);
   assign sel_word  = rd_line[{act_word, 5'b0} +: 32];
   assign dbg_state_o = state_q;

   dcache_line_store #(
      .NUM_LINES  (NUM_LINES),
      .LINE_BYTES (LINE_BYTES),
      .ADDR_W     (ADDR_W)
   ) u_store (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .rd_idx_i       (act_idx),
      .rd_valid_o     (rd_valid),
      .rd_dirty_o     (rd_dirty),
      .rd_tag_o       (rd_tag),
      .rd_line_o      (rd_line),
      .wr_en_i        (wr_en),
      .wr_line_i      (wr_line),
      .wr_idx_i       (act_idx),
      .wr_tag_i       (act_tag),
      .wr_line_data_i (mem_if.mem_rdata),
      .wr_word_sel_i  (act_word),
      .wr_word_i      (act_wdata)
   );

   // State register and miss-request latch; reset abandons any transaction in flight.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q     <= ST_IDLE;
         lat_addr_q  <= '0;
         lat_we_q    <= 1'b0;
         lat_wdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (latch_en) begin
            lat_addr_q  <= cpu_addr_i[ADDR_W-1:2];
            lat_we_q    <= cpu_we_i;
            lat_wdata_q <= cpu_wdata_i;
         end
      end
   end

   // Next state, stall, memory bus and store write controls.
   always_comb begin
      state_d          = state_q;
      cpu_stall_o      = 1'b0;
      cpu_rdata_o      = '0;
      mem_if.mem_req   = 1'b0;
      mem_if.mem_we    = 1'b0;
      mem_if.mem_addr  = '0;
      mem_if.mem_wdata = '0;
      wr_en            = 1'b0;
      wr_line          = 1'b0;
      latch_en         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cpu_req_i) begin
               if (hit) begin
                  if (cpu_we_i) wr_en = 1'b1;
                  else          cpu_rdata_o = sel_word;
               end else begin
                  cpu_stall_o = 1'b1;
                  latch_en    = 1'b1;
                  state_d     = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
               end
            end
         end
         ST_WRITEBACK: begin
            cpu_stall_o      = 1'b1;
            mem_if.mem_req   = 1'b1;
            mem_if.mem_we    = 1'b1;
            mem_if.mem_addr  = ADDR_W'(line_addr(64'(rd_tag), 64'(act_idx), INDEX_W, OFFSET_W));
            mem_if.mem_wdata = rd_line;
            if (mem_if.mem_ack) state_d = ST_ALLOCATE;
         end
         ST_ALLOCATE: begin
            cpu_stall_o     = 1'b1;
            mem_if.mem_req  = 1'b1;
            mem_if.mem_addr = ADDR_W'(line_addr(64'(act_tag), 64'(act_idx), INDEX_W, OFFSET_W));
            if (mem_if.mem_ack) begin
               wr_en   = 1'b1;
               wr_line = 1'b1;
               state_d = ST_RESOLVE;
            end
         end
         ST_RESOLVE: begin
            if (lat_we_q) wr_en = 1'b1;
            else          cpu_rdata_o = sel_word;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule
